// File: rtl/mem_pkg.sv
// Shared definitions for the memory line responder: line/address widths,
// default timing and depth, address field positions and the FSM state type.
// Used by mem_line_array and mem_line_responder.
package mem_pkg;

    localparam int LINE_W      = 256;
    localparam int ADDR_W      = 32;
    localparam int DEF_LATENCY = 10;
    localparam int DEF_DEPTH   = 512;

    // Byte address layout: [31:14] must be zero, [13:5] line index, [4:0] byte offset.
    localparam int OFF_MSB = 4;
    localparam int IDX_LSB = 5;
    localparam int IDX_MSB = 13;
    localparam int TAG_LSB = 14;

    // Counter is wide enough for the largest legal LATENCY (255).
    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } state_t;

    // Line index from a byte address, wrapped into the populated depth.
    function automatic logic [31:0] line_index(input logic [ADDR_W-1:0] addr,
                                               input int unsigned       depth);
        return 32'(addr[IDX_MSB:IDX_LSB]) % depth;
    endfunction

    // An address is out of range when it has upper tag bits or a byte offset.
    function automatic logic addr_out_of_range(input logic [ADDR_W-1:0] addr);
        return (addr[ADDR_W-1:TAG_LSB] != '0) || (addr[OFF_MSB:0] != '0);
    endfunction

endpackage

// File: rtl/mem_line_array.sv
// Line storage for the memory line responder: DEPTH lines of LINE_W bits,
// synchronous write, combinational read on the same index. Contents have no
// reset, so they persist across a responder reset.
module mem_line_array
    import mem_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                     i_clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_addr,
    input  logic [LINE_W-1:0]        i_wdata,
    output logic [LINE_W-1:0]        o_rdata
);

    logic [LINE_W-1:0] memory [DEPTH];

    // Write the addressed line on the clock edge the responder commits a write.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            memory[i_addr] <= i_wdata;
        end
    end

    assign o_rdata = memory[i_addr];

endmodule

// File: rtl/mem_line_responder.sv
// Fixed-latency line responder in front of mem_line_array.
//
// Handshake: the initiator raises enable_i with addr_i/data_i/write_i and
// holds them until ack_o. A request is accepted on a rising edge where the
// FSM is IDLE and enable_i=1; the inputs are latched then and ignored until
// the request completes. ack_o is a single-cycle pulse high during the
// LATENCY-th cycle counting the accepting cycle as the first; data_o carries
// the read line only during that pulse and is zero otherwise (and zero for
// writes). The cycle after the ACK cycle is IDLE, so back-to-back requests
// with enable_i held high are spaced LATENCY+1 cycles apart.
//
// Optional feature: define MEM_RANGE_CHECK_EN to add err_o, which pulses with
// ack_o for addresses with nonzero [31:14] or [4:0]; such requests neither
// write nor return data. Without it those bits are ignored and the index
// wraps modulo DEPTH.
module mem_line_responder
    import mem_pkg::*;
#(
    parameter int LATENCY = DEF_LATENCY,
    parameter int DEPTH   = DEF_DEPTH
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [LINE_W-1:0] data_i,
    input  logic              enable_i,
    input  logic              write_i,
    output logic              ack_o,
    output logic [LINE_W-1:0] data_o
`ifdef MEM_RANGE_CHECK_EN
    ,
    output logic              err_o
`endif
);

    localparam int             AW       = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    // Request latches and FSM state
    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic [LINE_W-1:0] r_wdata;
    logic              r_write;

    // Registered outputs
    logic              r_ack;
    logic [LINE_W-1:0] r_data;
    logic              r_err;

    // Datapath
    logic [31:0]       w_idx_full;
    logic [AW-1:0]     w_idx;
    logic [LINE_W-1:0] w_rdata;
    logic              w_bad;
    logic              w_done;
    logic              w_we;
    logic              w_unused;

    assign w_idx_full = line_index(r_addr, DEPTH);
    assign w_idx      = w_idx_full[AW-1:0];

`ifdef MEM_RANGE_CHECK_EN
    assign w_bad = addr_out_of_range(r_addr);
`else
    assign w_bad = 1'b0;
`endif

    // Last WAIT cycle: the next edge enters ACK and commits any write.
    assign w_done = (r_state == WAIT) && (r_cnt <= CNT_W'(1));
    assign w_we   = w_done && r_write && !w_bad;

    // Address bits outside the index field only matter to the range check.
    assign w_unused = ^{r_addr[ADDR_W-1:TAG_LSB], r_addr[OFF_MSB:0],
                        w_idx_full[31:AW], r_err};

    mem_line_array #(
        .DEPTH (DEPTH)
    ) u_array (
        .i_clk   (clk_i),
        .i_we    (w_we),
        .i_addr  (w_idx),
        .i_wdata (r_wdata),
        .o_rdata (w_rdata)
    );

    // Request FSM: accept in IDLE, count down in WAIT, pulse outputs in ACK.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_write <= 1'b0;
            r_ack   <= 1'b0;
            r_data  <= '0;
            r_err   <= 1'b0;
        end else begin
            r_ack  <= 1'b0;
            r_data <= '0;
            r_err  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (enable_i) begin
                        r_addr  <= addr_i;
                        r_wdata <= data_i;
                        r_write <= write_i;
                        r_cnt   <= CNT_LOAD;
                        r_state <= WAIT;
                    end
                end
                WAIT: begin
                    if (w_done) begin
                        r_cnt   <= '0;
                        r_state <= ACK;
                        r_ack   <= 1'b1;
                        r_err   <= w_bad;
                        if (!r_write && !w_bad) begin
                            r_data <= w_rdata;
                        end
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                ACK: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign ack_o  = r_ack;
    assign data_o = r_data;
`ifdef MEM_RANGE_CHECK_EN
    assign err_o  = r_err;
`endif

endmodule

// File: tb/tb_mem_line_responder.sv
// Directed bench for mem_line_responder (LATENCY=10, DEPTH=512).
// Define MEM_RANGE_CHECK_EN when building to exercise err_o.
module tb_mem_line_responder;
    import mem_pkg::*;

    localparam int LAT = 10;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic [ADDR_W-1:0] addr_i;
    logic [LINE_W-1:0] data_i;
    logic              enable_i;
    logic              write_i;
    logic              ack_o;
    logic [LINE_W-1:0] data_o;
`ifdef MEM_RANGE_CHECK_EN
    logic              err_o;
`endif

    int n_vec  = 0;
    int n_miss = 0;

    mem_line_responder #(
        .LATENCY (LAT),
        .DEPTH   (DEF_DEPTH)
    ) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .addr_i   (addr_i),
        .data_i   (data_i),
        .enable_i (enable_i),
        .write_i  (write_i),
        .ack_o    (ack_o),
        .data_o   (data_o)
`ifdef MEM_RANGE_CHECK_EN
        ,
        .err_o    (err_o)
`endif
    );

    // Clock
    always #5 clk_i = ~clk_i;

    // Watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [LINE_W-1:0] pat(input int i);
        return {8{32'hA5C3_0000 | 32'(i)}};
    endfunction

    function automatic logic get_err();
`ifdef MEM_RANGE_CHECK_EN
        return err_o;
`else
        return 1'b0;
`endif
    endfunction

    task automatic check(input string tag, input logic [LINE_W-1:0] obs,
                         input logic [LINE_W-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Issue one request, wait (bounded) for ack_o, then drop enable_i and
    // step one more cycle so the FSM is back in IDLE. lat=0 means no ack.
    task automatic do_req(input logic [ADDR_W-1:0] a, input logic [LINE_W-1:0] d,
                          input logic w, output int lat,
                          output logic [LINE_W-1:0] dout, output logic err);
        addr_i   = a;
        data_i   = d;
        write_i  = w;
        enable_i = 1'b1;
        lat  = 0;
        dout = '0;
        err  = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (ack_o) begin
                lat  = k;
                dout = data_o;
                err  = get_err();
                break;
            end
        end
        enable_i = 1'b0;
        tick();
    endtask

    logic [LINE_W-1:0] line0;
    logic [LINE_W-1:0] ecfa;
    logic [LINE_W-1:0] d1, d2, d3, d4;
    logic [LINE_W-1:0] dout, dfirst, dsecond;
    logic              err;
    int                lat;

    initial begin
        // Preload
        for (int i = 0; i < 16; i++) begin
            line0[255 - 16*i -: 16] = {4{4'(i)}};
        end
        ecfa = {16{16'hECFA}};
        d1   = {8{32'h1234_5678}};
        d2   = {8{32'hDEAD_BEEF}};
        d3   = {8{32'h0BAD_F00D}};
        d4   = {8{32'h5555_AAAA}};
        dut.u_array.memory[0] = line0;
        for (int i = 1; i < DEF_DEPTH; i++) begin
            dut.u_array.memory[i] = pat(i);
        end

        // Reset
        rst_i    = 1'b0;
        enable_i = 1'b0;
        write_i  = 1'b0;
        addr_i   = '0;
        data_i   = '0;
        #1;
        check("reset_ack", 256'(ack_o), 256'(0));
        check("reset_data", data_o, '0);
        tick();
        tick();
        check("reset_state", 256'(dut.r_state), 256'(IDLE));
        check("reset_cnt", 256'(dut.r_cnt), 256'(0));
        rst_i = 1'b1;
        tick();
        tick();
        check("idle_no_ack", 256'(ack_o), 256'(0));

        // Read line 0
        do_req(32'h0000_0000, '0, 1'b0, lat, dout, err);
        check("rd0_latency", 256'(lat), 256'(LAT));
        check("rd0_data", dout, line0);
        check("rd0_pulse_end", 256'(ack_o), 256'(0));
        check("rd0_data_idle", data_o, '0);

        // Write line 2, then read it back
        do_req(32'h0000_0040, ecfa, 1'b1, lat, dout, err);
        check("wr40_latency", 256'(lat), 256'(LAT));
        check("wr40_data_zero", dout, '0);
        check("wr40_mem", dut.u_array.memory[2], ecfa);
        check("wr40_pulse_end", 256'(ack_o), 256'(0));
        do_req(32'h0000_0040, '0, 1'b0, lat, dout, err);
        check("rd40_latency", 256'(lat), 256'(LAT));
        check("rd40_data", dout, ecfa);

        // Inputs change during WAIT of a write to line 16
        addr_i   = 32'h0000_0200;
        data_i   = d1;
        write_i  = 1'b1;
        enable_i = 1'b1;
        lat  = 0;
        dout = '0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (k == 1) begin
                addr_i  = 32'h0000_0220;
                data_i  = d2;
                write_i = 1'b0;
            end
            if (ack_o) begin
                lat  = k;
                dout = data_o;
                break;
            end
        end
        enable_i = 1'b0;
        tick();
        check("wait_chg_latency", 256'(lat), 256'(LAT));
        check("wait_chg_data_zero", dout, '0);
        check("wait_chg_line16", dut.u_array.memory[16], d1);
        check("wait_chg_line17", dut.u_array.memory[17], pat(17));
        check("wait_chg_line15", dut.u_array.memory[15], pat(15));

        // Reset in cycle 5 of a write to line 32
        begin
            int acks;
            acks     = 0;
            addr_i   = 32'h0000_0400;
            data_i   = d3;
            write_i  = 1'b1;
            enable_i = 1'b1;
            for (int k = 1; k <= 5; k++) begin
                tick();
                if (ack_o) acks++;
            end
            rst_i    = 1'b0;
            enable_i = 1'b0;
            #1;
            check("rst_mid_ack", 256'(ack_o), 256'(0));
            check("rst_mid_data", data_o, '0);
            check("rst_mid_state", 256'(dut.r_state), 256'(IDLE));
            tick();
            tick();
            rst_i = 1'b1;
            for (int k = 0; k < 15; k++) begin
                tick();
                if (ack_o) acks++;
            end
            check("rst_mid_no_ack", 256'(acks), 256'(0));
            check("rst_mid_line32", dut.u_array.memory[32], pat(32));
        end
        do_req(32'h0000_0400, '0, 1'b0, lat, dout, err);
        check("post_rst_latency", 256'(lat), 256'(LAT));
        check("post_rst_data", dout, pat(32));

        // enable_i held high across two reads
        begin
            int   acks, first, second;
            logic prev, consec;
            acks = 0; first = 0; second = 0;
            prev = 1'b0; consec = 1'b0;
            dfirst = '0; dsecond = '0;
            addr_i   = 32'h0000_0000;
            write_i  = 1'b0;
            enable_i = 1'b1;
            for (int k = 1; k <= 30; k++) begin
                tick();
                if (ack_o) begin
                    if (prev) consec = 1'b1;
                    acks++;
                    if (acks == 1) begin
                        first  = k;
                        dfirst = data_o;
                        addr_i = 32'h0000_0020;
                    end else if (acks == 2) begin
                        second   = k;
                        dsecond  = data_o;
                        enable_i = 1'b0;
                    end
                end
                prev = ack_o;
            end
            enable_i = 1'b0;
            check("b2b_first_latency", 256'(first), 256'(LAT));
            check("b2b_spacing", 256'(second - first), 256'(LAT + 1));
            check("b2b_ack_count", 256'(acks), 256'(2));
            check("b2b_no_consecutive", 256'(consec), 256'(0));
            check("b2b_first_data", dfirst, line0);
            check("b2b_second_data", dsecond, pat(1));
        end

        // Highest index
        do_req(32'h0000_3FE0, '0, 1'b0, lat, dout, err);
        check("rd_top_latency", 256'(lat), 256'(LAT));
        check("rd_top_data", dout, pat(511));

        // Nonzero byte offset
        do_req(32'h0000_0045, '0, 1'b0, lat, dout, err);
        check("rd_offset_latency", 256'(lat), 256'(LAT));
`ifdef MEM_RANGE_CHECK_EN
        check("rd_offset_data", dout, '0);
        check("rd_offset_err", 256'(err), 256'(1));
`else
        check("rd_offset_data", dout, ecfa);
`endif

        // Address with tag bit set aliases onto line 0
        do_req(32'h0000_4000, d4, 1'b1, lat, dout, err);
        check("wr_tag_latency", 256'(lat), 256'(LAT));
        check("wr_tag_data_zero", dout, '0);
`ifdef MEM_RANGE_CHECK_EN
        check("wr_tag_err", 256'(err), 256'(1));
        check("wr_tag_line0", dut.u_array.memory[0], line0);
        check("err_idle", 256'(err_o), 256'(0));
`else
        check("wr_tag_line0", dut.u_array.memory[0], d4);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/mem_line_responder.md
MEM_LINE_RESPONDER -- requirements
Module: mem_line_responder

Interface
REQ-001 SHALL have parameter LATENCY, default 10: cycles from request acceptance to ack_o (legal range 2..255).
REQ-002 SHALL have parameter DEPTH, default 512: number of 256-bit lines held.
REQ-003 SHALL have port clk_i, input, 1: single clock; all logic on rising edge.
REQ-004 SHALL have port rst_i, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port addr_i, input, 32: byte address; line index = addr_i[13:5].
REQ-006 SHALL have port data_i, input, 256: write line data.
REQ-007 SHALL have port enable_i, input, 1: request valid, held high by the initiator until ack_o.
REQ-008 SHALL have port write_i, input, 1: 1 = write line, 0 = read line; sampled with enable_i.
REQ-009 SHALL have port ack_o, output, 1: one-cycle completion pulse.
REQ-010 SHALL have port data_o, output, 256: read line data, valid only while ack_o=1.

Function
REQ-011 SHALL implement FSM states IDLE, WAIT and ACK.
REQ-012 In IDLE with enable_i=1, SHALL latch addr_i, data_i and write_i, load counter with LATENCY-1, and go to WAIT.
REQ-013 In WAIT, SHALL decrement the counter each cycle, ignore input changes, and go to ACK when the counter reaches 1.
REQ-014 SHALL assert ack_o for exactly one cycle in ACK, on the LATENCY-th rising edge after acceptance, then return to IDLE.
REQ-015 On a write request, SHALL update the line at the ACK edge with the latched data, and SHALL drive data_o to zero during that ack.
REQ-016 On a read request, SHALL drive data_o with the latched-index line during ack, and SHALL drive zero at all other times.
REQ-017 SHALL sample enable_i=1 in the IDLE cycle after ACK as a new request; minimum request spacing is LATENCY+1 cycles.
REQ-018 SHALL ignore enable_i=0 in IDLE with no state change, and SHALL never hold more than one request outstanding.
REQ-019 SHALL leave memory contents uninitialised by hardware; the bench preloads lines hierarchically through the array named memory.

Reset
REQ-020 rst_i=0 SHALL immediately force IDLE, counter=0, ack_o=0 and data_o=0.
REQ-021 A reset while in WAIT or ACK SHALL drop the pending request with no memory write.
REQ-022 Memory contents SHALL survive reset.

Configuration
REQ-023 With macro MEM_RANGE_CHECK_EN defined, SHALL add output err_o (1 bit, reset 0).
REQ-024 With MEM_RANGE_CHECK_EN, err_o SHALL pulse with ack_o when the latched address has addr[31:14]≠0 or addr[4:0]≠0; that request SHALL perform no write and return data_o=0.
REQ-025 Without MEM_RANGE_CHECK_EN, SHALL have no err_o port, ignore addr_i[31:14] and addr_i[4:0], and wrap the index modulo DEPTH.

Structure
REQ-026 Package mem_pkg SHALL hold LINE_W=256, ADDR_W=32, the default LATENCY and DEPTH, the offset/index bit positions, and the FSM state enum.
REQ-027 Storage SHALL be a sub-module mem_line_array: a synchronous-write array of DEPTH×LINE_W with combinational read.
REQ-028 FSM, counter and request latches SHALL reside in mem_line_responder.

Verification
REQ-029 Preload line 0 = 0000_1111_…_EEEE_FFFF; read addr 0x0000_0000 -> ack_o high exactly 10 cycles after acceptance; data_o equals line 0.
REQ-030 Write addr 0x0000_0040 with data all ECFA, then read it back -> write ack after 10 cycles with data_o=0; read returns all ECFA.
REQ-031 Change addr_i and data_i during WAIT of a write to 0x0200 -> line 16 receives the originally latched data; no other line changes.
REQ-032 Assert rst_i=0 at cycle 5 of a write to 0x0400 -> no ack_o; line 32 unchanged; data_o=0; next request accepted normally.
REQ-033 Hold enable_i high continuously with reads of 0x0000 then 0x0020 -> ack_o pulses 11 cycles apart, never two consecutive cycles.
REQ-034 With MEM_RANGE_CHECK_EN, write addr 0x0000_4000 -> err_o and ack_o pulse together; line 0 unchanged; without the macro, line 0 is overwritten.
